// File: rtl/tt_ram_byte_port_if.sv
// Command/response and RAM-macro signal bundle for tt_ram_byte_port.
// master = pin decoder plus RAM macro side, slave = byte-port controller.
interface tt_ram_byte_port_if #(
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned WORD_ADDR_W = 5
);
    localparam int unsigned LANE_W = $clog2(WORD_BYTES);
    localparam int unsigned BA_W   = WORD_ADDR_W + LANE_W;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [BA_W-1:0]           cmd_addr;
    logic [7:0]                cmd_wdata;
    logic                      auto_inc;
    logic                      rsp_valid;
    logic [7:0]                rsp_data;
    logic [BA_W-1:0]           ptr;
    logic                      ram_en;
    logic [WORD_ADDR_W-1:0]    ram_addr;
    logic [WORD_BYTES-1:0]     ram_we;
    logic [8*WORD_BYTES-1:0]   ram_wdata;
    logic [8*WORD_BYTES-1:0]   ram_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, auto_inc, ram_rdata,
        input  cmd_ready, rsp_valid, rsp_data, ptr,
               ram_en, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, auto_inc, ram_rdata,
        output cmd_ready, rsp_valid, rsp_data, ptr,
               ram_en, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/tt_ram_byte_port.sv
// Byte-access controller for a word-organised synchronous RAM macro:
// byte pointer with optional post-increment, lane-masked writes, blocking reads.
module tt_ram_byte_port #(
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned WORD_ADDR_W = 5,
    parameter int unsigned RAM_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    tt_ram_byte_port_if.slave   bus
);
    localparam int unsigned LANE_W = $clog2(WORD_BYTES);
    localparam int unsigned BA_W   = WORD_ADDR_W + LANE_W;
    localparam int unsigned CNT_W  = 2;

    localparam logic [1:0] OP_SET_PTR = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t                    state_q;
    logic                      cmd_ready_q;
    logic                      rsp_valid_q;
    logic [7:0]                rsp_data_q;
    logic [BA_W-1:0]           ptr_q;
    logic [LANE_W-1:0]         lane_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      ram_en_q;
    logic [WORD_ADDR_W-1:0]    ram_addr_q;
    logic [WORD_BYTES-1:0]     ram_we_q;
    logic [8*WORD_BYTES-1:0]   ram_wdata_q;

    logic                      accept_c;
    logic [LANE_W-1:0]         lane_c;
    logic [WORD_ADDR_W-1:0]    word_c;
    logic [BA_W-1:0]           ptr_inc_c;

    assign accept_c  = bus.cmd_valid && cmd_ready_q;
    assign lane_c    = ptr_q[LANE_W-1:0];
    assign word_c    = ptr_q[BA_W-1:LANE_W];
    assign ptr_inc_c = bus.auto_inc ? ptr_q + BA_W'(1) : ptr_q;

    // ram_en/ram_we default low each edge so an access lasts exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ptr_q       <= '0;
            lane_q      <= '0;
            cnt_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        case (bus.cmd_op)
                            OP_SET_PTR: ptr_q <= bus.cmd_addr;
                            OP_WRITE: begin
                                ram_en_q    <= 1'b1;
                                ram_addr_q  <= word_c;
                                ram_we_q    <= WORD_BYTES'(1) << lane_c;
                                ram_wdata_q <= {WORD_BYTES{bus.cmd_wdata}};
                                ptr_q       <= ptr_inc_c;
                            end
                            OP_READ: begin
                                ram_en_q    <= 1'b1;
                                ram_addr_q  <= word_c;
                                lane_q      <= lane_c;
                                cnt_q       <= '0;
                                cmd_ready_q <= 1'b0;
                                state_q     <= RD_WAIT;
                                ptr_q       <= ptr_inc_c;
                            end
                            default: ;
                        endcase
                    end
                end
                RD_WAIT: begin
                    // Macro output is valid RAM_LAT edges after the enable edge
                    if (cnt_q == CNT_W'(RAM_LAT)) begin
                        rsp_data_q  <= bus.ram_rdata[{lane_q, 3'b000} +: 8];
                        rsp_valid_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.ptr       = ptr_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_tt_ram_byte_port.sv
// Directed bench for tt_ram_byte_port: RAM_LAT=1 instance with vector table
// and timing sequences, plus a RAM_LAT=2 instance for read latency.
module tb_tt_ram_byte_port;
    localparam int unsigned WB  = 4;
    localparam int unsigned WAW = 5;
    localparam int unsigned BAW = 7;

    localparam logic [1:0] SETP = 2'b00;
    localparam logic [1:0] WR   = 2'b01;
    localparam logic [1:0] RD   = 2'b10;
    localparam logic [1:0] NOP  = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_ram_byte_port_if #(.WORD_BYTES(WB), .WORD_ADDR_W(WAW)) b1 ();
    tt_ram_byte_port_if #(.WORD_BYTES(WB), .WORD_ADDR_W(WAW)) b2 ();

    tt_ram_byte_port #(.WORD_BYTES(WB), .WORD_ADDR_W(WAW), .RAM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    tt_ram_byte_port #(.WORD_BYTES(WB), .WORD_ADDR_W(WAW), .RAM_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));

    int n_vec = 0;
    int n_mis = 0;
    int acc1 = 0;
    int acc2 = 0;

    logic [31:0] mem1 [32];
    logic [31:0] mem2 [32];
    logic [31:0] pipe2;
    logic        pre1_en = 1'b0, pre2_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    // RAM_LAT=1 macro model
    always @(posedge clk) begin
        if (pre1_en) mem1[pre_addr] <= pre_data;
        if (b1.ram_en) begin
            if (b1.ram_we == '0) b1.ram_rdata <= mem1[b1.ram_addr];
            for (int i = 0; i < 4; i++)
                if (b1.ram_we[i]) mem1[b1.ram_addr][8*i +: 8] <= b1.ram_wdata[8*i +: 8];
        end
        if (b1.cmd_valid && b1.cmd_ready) acc1 <= acc1 + 1;
    end

    // RAM_LAT=2 macro model: one extra output register
    always @(posedge clk) begin
        if (pre2_en) mem2[pre_addr] <= pre_data;
        if (b2.ram_en && b2.ram_we == '0) pipe2 <= mem2[b2.ram_addr];
        b2.ram_rdata <= pipe2;
        if (b2.cmd_valid && b2.cmd_ready) acc2 <= acc2 + 1;
    end

    typedef struct {
        logic [1:0] op;
        logic [6:0] addr;
        logic [7:0] wd;
        logic       ai;
        logic       has_rsp;
        logic [7:0] rsp;
        logic [6:0] ptr;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int which, input logic [4:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        if (which == 1) pre1_en = 1'b1; else pre2_en = 1'b1;
        tick();
        pre1_en = 1'b0;
        pre2_en = 1'b0;
    endtask

    // Returns at accept edge E0 + #1
    task automatic send(input logic [1:0] op, input logic [6:0] a, input logic [7:0] wd,
                        input logic ai);
        logic done = 1'b0;
        logic rdy;
        b1.cmd_op    = op;
        b1.cmd_addr  = a;
        b1.cmd_wdata = wd;
        b1.auto_inc  = ai;
        b1.cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            rdy = b1.cmd_ready;
            tick();
            if (rdy) done = 1'b1;
        end
        b1.cmd_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_mis++;
            $display("FAIL send_timeout: op %b never accepted", op);
        end
    endtask

    task automatic wait_rsp(input string nm, input logic [7:0] exp);
        logic got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (b1.rsp_valid) begin
                got = 1'b1;
                chk(nm, 32'(b1.rsp_data), 32'(exp));
            end
        end
        if (!got) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s: no rsp_valid, expected data %h", nm, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ready"},  32'(b1.cmd_ready), 32'd1);
        chk({nm, "_rspv"},   32'(b1.rsp_valid), 32'd0);
        chk({nm, "_rspd"},   32'(b1.rsp_data),  32'd0);
        chk({nm, "_ptr"},    32'(b1.ptr),       32'd0);
        chk({nm, "_en"},     32'(b1.ram_en),    32'd0);
        chk({nm, "_we"},     32'(b1.ram_we),    32'd0);
        chk({nm, "_addr"},   32'(b1.ram_addr),  32'd0);
        chk({nm, "_wdata"},  b1.ram_wdata,      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        b1.cmd_valid = 1'b0; b1.cmd_op = NOP; b1.cmd_addr = '0; b1.cmd_wdata = '0; b1.auto_inc = 1'b0;
        b2.cmd_valid = 1'b0; b2.cmd_op = NOP; b2.cmd_addr = '0; b2.cmd_wdata = '0; b2.auto_inc = 1'b0;

        vt[0]  = '{SETP, 7'h20, 8'h00, 1'b0, 1'b0, 8'h00, 7'h20};
        vt[1]  = '{WR,   7'h00, 8'h01, 1'b1, 1'b0, 8'h00, 7'h21};
        vt[2]  = '{WR,   7'h00, 8'h02, 1'b1, 1'b0, 8'h00, 7'h22};
        vt[3]  = '{WR,   7'h00, 8'h03, 1'b1, 1'b0, 8'h00, 7'h23};
        vt[4]  = '{WR,   7'h00, 8'h04, 1'b1, 1'b0, 8'h00, 7'h24};
        vt[5]  = '{WR,   7'h00, 8'h05, 1'b1, 1'b0, 8'h00, 7'h25};
        vt[6]  = '{SETP, 7'h21, 8'h00, 1'b1, 1'b0, 8'h00, 7'h21};
        vt[7]  = '{RD,   7'h00, 8'h00, 1'b1, 1'b1, 8'h02, 7'h22};
        vt[8]  = '{RD,   7'h00, 8'h00, 1'b0, 1'b1, 8'h03, 7'h22};
        vt[9]  = '{NOP,  7'h55, 8'h99, 1'b1, 1'b0, 8'h00, 7'h22};
        vt[10] = '{RD,   7'h00, 8'h00, 1'b1, 1'b1, 8'h03, 7'h23};
        vt[11] = '{RD,   7'h00, 8'h00, 1'b1, 1'b1, 8'h04, 7'h24};
        vt[12] = '{RD,   7'h00, 8'h00, 1'b0, 1'b1, 8'h05, 7'h24};
        vt[13] = '{SETP, 7'h22, 8'h00, 1'b0, 1'b0, 8'h00, 7'h22};
        vt[14] = '{WR,   7'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 7'h22};
        vt[15] = '{RD,   7'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 7'h23};
        vt[16] = '{SETP, 7'h20, 8'h00, 1'b0, 1'b0, 8'h00, 7'h20};
        vt[17] = '{RD,   7'h00, 8'h00, 1'b0, 1'b1, 8'h01, 7'h20};

        preload(1, 5'd1,  32'h11002233);
        preload(1, 5'd31, 32'hDEADBEEF);
        preload(2, 5'd0,  32'h000000C3);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Reset during RD_WAIT discards the pending response
        send(SETP, 7'h13, 8'h00, 1'b0);
        send(WR, 7'h00, 8'h77, 1'b0);
        send(RD, 7'h00, 8'h00, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrd_rst");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("midrd_no_rsp", 32'(b1.rsp_valid), 32'd0);
        end
        chk("midrd_ready", 32'(b1.cmd_ready), 32'd1);

        // Direct lane write
        send(SETP, 7'h06, 8'h00, 1'b0);
        send(WR, 7'h00, 8'hA5, 1'b0);
        chk("wr_en",    32'(b1.ram_en),   32'd1);
        chk("wr_addr",  32'(b1.ram_addr), 32'd1);
        chk("wr_we",    32'(b1.ram_we),   32'b0100);
        chk("wr_wdata", b1.ram_wdata,     32'hA5A5A5A5);
        chk("wr_ptr",   32'(b1.ptr),      32'h06);
        tick();
        chk("wr_en_off",   32'(b1.ram_en),   32'd0);
        chk("wr_we_off",   32'(b1.ram_we),   32'd0);
        chk("wr_addr_hold",32'(b1.ram_addr), 32'd1);
        chk("wr_mem",      mem1[1],          32'h11A52233);

        // Read-back timing at RAM_LAT=1
        b1.cmd_op = RD; b1.auto_inc = 1'b0; b1.cmd_valid = 1'b1;
        tick();
        b1.cmd_valid = 1'b0;
        chk("rd_e0_ready", 32'(b1.cmd_ready), 32'd0);
        chk("rd_e0_en",    32'(b1.ram_en),    32'd1);
        chk("rd_e0_we",    32'(b1.ram_we),    32'd0);
        chk("rd_e0_rspv",  32'(b1.rsp_valid), 32'd0);
        tick();
        chk("rd_e1_ready", 32'(b1.cmd_ready), 32'd0);
        chk("rd_e1_rspv",  32'(b1.rsp_valid), 32'd0);
        chk("rd_e1_en",    32'(b1.ram_en),    32'd0);
        tick();
        chk("rd_e2_rspv",  32'(b1.rsp_valid), 32'd1);
        chk("rd_e2_data",  32'(b1.rsp_data),  32'hA5);
        chk("rd_e2_ready", 32'(b1.cmd_ready), 32'd1);
        tick();
        chk("rd_e3_rspv",  32'(b1.rsp_valid), 32'd0);
        chk("rd_e3_hold",  32'(b1.rsp_data),  32'hA5);

        // Back-to-back auto-increment writes
        send(SETP, 7'h00, 8'h00, 1'b0);
        a0 = acc1;
        b1.cmd_op = WR; b1.auto_inc = 1'b1; b1.cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b1.cmd_wdata = 8'(8'h10 + i);
            chk("stream_ready", 32'(b1.cmd_ready), 32'd1);
            tick();
        end
        b1.cmd_valid = 1'b0;
        tick();
        chk("stream_accepts", 32'(acc1 - a0), 32'd8);
        chk("stream_w0",      mem1[0],        32'h13121110);
        chk("stream_w1",      mem1[1],        32'h17161514);
        chk("stream_ptr",     32'(b1.ptr),    32'h08);

        // Pointer wrap from all-ones
        send(SETP, 7'h7F, 8'h00, 1'b0);
        send(RD, 7'h00, 8'h00, 1'b1);
        chk("wrap_ptr",  32'(b1.ptr),      32'h00);
        chk("wrap_addr", 32'(b1.ram_addr), 32'd31);
        wait_rsp("wrap_rsp", 8'hDE);
        send(WR, 7'h00, 8'h5A, 1'b0);
        chk("wrap_wr_addr", 32'(b1.ram_addr), 32'd0);
        chk("wrap_wr_we",   32'(b1.ram_we),   32'b0001);
        tick();
        chk("wrap_wr_mem",  mem1[0],          32'h1312115A);

        // Vector table
        for (int v = 0; v < 18; v++) begin
            send(vt[v].op, vt[v].addr, vt[v].wd, vt[v].ai);
            if (vt[v].has_rsp) wait_rsp($sformatf("vec%0d_rsp", v), vt[v].rsp);
            chk($sformatf("vec%0d_ptr", v), 32'(b1.ptr), 32'(vt[v].ptr));
        end

        // RAM_LAT=2 instance: READ then a held NOP
        b2.cmd_op = RD; b2.auto_inc = 1'b0; b2.cmd_valid = 1'b1;
        tick();
        b2.cmd_op = NOP;
        a0 = acc2;
        chk("lat2_e0_ready", 32'(b2.cmd_ready), 32'd0);
        tick();
        chk("lat2_e1_ready", 32'(b2.cmd_ready), 32'd0);
        chk("lat2_e1_rspv",  32'(b2.rsp_valid), 32'd0);
        tick();
        chk("lat2_e2_ready", 32'(b2.cmd_ready), 32'd0);
        chk("lat2_e2_rspv",  32'(b2.rsp_valid), 32'd0);
        chk("lat2_no_acc",   32'(acc2 - a0),    32'd0);
        tick();
        chk("lat2_e3_rspv",  32'(b2.rsp_valid), 32'd1);
        chk("lat2_e3_data",  32'(b2.rsp_data),  32'hC3);
        chk("lat2_e3_ready", 32'(b2.cmd_ready), 32'd1);
        tick();
        b2.cmd_valid = 1'b0;
        chk("lat2_e4_acc",   32'(acc2 - a0),    32'd1);
        chk("lat2_e4_rspv",  32'(b2.rsp_valid), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/tt_ram_byte_port.md
Name: tt_ram_byte_port

Overview:
Parametrised byte-access controller for a word-organised synchronous RAM macro (RAM32-class) in the Tiny Tapeout designs.
- Presents an 8-bit command/response interface with a byte pointer, optional auto-increment and blocking reads.
- Drives the macro's registered enable/address/byte-write-enable/data port.
- Extracts the addressed byte lane from the returned word.
- Sits between the tt_um top-level pin decoding and the RAM macro instance.

Parameters:
WORD_BYTES, 4, bytes per RAM word; legal values 2, 4, 8; LANE_W = log2(WORD_BYTES).
WORD_ADDR_W, 5, RAM word-address width; BA_W = WORD_ADDR_W + LANE_W.
RAM_LAT, 1, macro read latency in cycles; legal values 1, 2.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted on an edge where cmd_valid && cmd_ready.
cmd_op  input  2  00 SET_PTR, 01 WRITE, 10 READ, 11 NOP.
cmd_addr  input  BA_W  new byte pointer; used by SET_PTR only.
cmd_wdata  input  8  write byte; used by WRITE only.
auto_inc  input  1  level, sampled at accept; 1 = post-increment ptr after WRITE/READ.
rsp_valid  output  1  one-cycle pulse; rsp_data valid.
rsp_data  output  8  read byte; holds its value between responses.
ptr  output  BA_W  current byte pointer.
ram_en  output  1  macro enable; high only in access cycles.
ram_addr  output  WORD_ADDR_W  word address = ptr[BA_W-1:LANE_W].
ram_we  output  WORD_BYTES  per-lane write enable.
ram_wdata  output  8*WORD_BYTES  write data.
ram_rdata  input  8*WORD_BYTES  macro read data.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, ptr=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, lane register=0.
- Reset mid-read: pending response is discarded; no rsp_valid after release.
- Lane = ptr[LANE_W-1:0] at accept. All ram_* outputs are registered at the accept edge E0 and held for exactly one cycle. Afterwards ram_en=0 and ram_we=0; ram_addr and ram_wdata keep their last value.
- SET_PTR: ptr <= cmd_addr at E0. auto_inc is ignored. No RAM access.
- NOP: accepted and has no effect.
- WRITE, registered at E0:
  - ram_en=1, ram_addr=word, ram_we=one-hot(lane).
  - ram_wdata = cmd_wdata replicated into every lane.
  - cmd_ready stays 1, so back-to-back writes run one per cycle.
- READ, registered at E0:
  - ram_en=1, ram_we=0. Lane is captured into the lane register. FSM goes to RD_WAIT and cmd_ready goes 0.
  - A counter tracks RAM_LAT edges. At edge E(1+RAM_LAT): rsp_data <= ram_rdata[8*lane +: 8], rsp_valid=1 for one cycle, cmd_ready=1, FSM goes to IDLE.
  - Next command can be accepted at E(2+RAM_LAT).
- Auto-increment: when auto_inc=1 at accept of WRITE/READ, ptr <= ptr+1 at E0, modulo 2^BA_W. All-ones wraps to 0.
  - Crossing a lane boundary is transparent; the next access goes to the next word.
  - The response byte uses the pre-increment lane.
- cmd_valid=0 in IDLE: no state change and no RAM activity.
- cmd_op values other than the four defined do not exist (2-bit field); 11 is NOP.
- FSM states: IDLE, RD_WAIT. There are no other states.

Test Plan:
- Reset with rst_n=0 mid RD_WAIT, release -> all outputs at reset values, no rsp_valid within 5 cycles, cmd_ready=1.
- Direct write: SET_PTR 0x06, WRITE 0xA5 (auto_inc=0) -> one cycle with ram_en=1, ram_addr=1, ram_we=0100, ram_wdata=0xA5A5A5A5; ptr stays 0x06.
- Read back (model RAM word1=0x11A52233), READ at ptr 0x06 -> rsp_valid exactly at E2, rsp_data=0xA5, cmd_ready low during E0..E2 only.
- Streaming: SET_PTR 0x00, auto_inc=1, WRITE 0x10..0x17 back-to-back -> eight accepts in eight cycles; words 0 and 1 read 0x13121110 and 0x17161514; ptr=0x08.
- Wrap: SET_PTR 0x7F, auto_inc=1, READ -> response from word31 lane3, ptr=0x00. Following WRITE 0x5A hits word0 lane0.
- RAM_LAT=2 build: READ -> rsp_valid at E3, no accept at E1/E2 despite cmd_valid=1; NOP then accepted at E4.
